// File: rtl/regbank_mp.sv
// regbank_mp: multi-read-port general register bank for the async ARM core.
// Holds DEPTH general registers (top one is the PC) plus a CPSR register.
// Optional scoreboard locking: define REGBANK_SCOREBOARD_EN.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   rdReq/rdAddr        per-port read request and index (packed per port)
//   rdReady             per-port accept indication
//   rdValid/rdData      one-cycle data pulse per accepted read, data held after
//   wrEn/wrAddr/wrData  writeback write port
//   pcWrEn/pcIn/pcOut   PC (register DEPTH-1) update and current value
//   cpsrWrEn/cpsrIn     CPSR update; cpsrOut is the current CPSR
//   lockSet/lockAddr    (REGBANK_SCOREBOARD_EN only) mark a pending writeback
module regbank_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD-1:0]        rdReq,
    input  logic [NUM_RD*ADDR_W-1:0] rdAddr,
    output logic [NUM_RD-1:0]        rdReady,
    output logic [NUM_RD-1:0]        rdValid,
    output logic [NUM_RD*DATA_W-1:0] rdData,
    input  logic                     wrEn,
    input  logic [ADDR_W-1:0]        wrAddr,
    input  logic [DATA_W-1:0]        wrData,
    input  logic                     pcWrEn,
    input  logic [DATA_W-1:0]        pcIn,
    output logic [DATA_W-1:0]        pcOut,
    input  logic                     cpsrWrEn,
    input  logic [DATA_W-1:0]        cpsrIn,
`ifdef REGBANK_SCOREBOARD_EN
    input  logic                     lockSet,
    input  logic [ADDR_W-1:0]        lockAddr,
`endif
    output logic [DATA_W-1:0]        cpsrOut
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] cpsr;

    logic [ADDR_W-1:0] addr [NUM_RD];
    logic [DATA_W-1:0] fwd  [NUM_RD];
    logic [NUM_RD-1:0] accept;
    logic              wb_en;

    // A writeback aimed at the PC loses to a simultaneous fetch PC load.
    assign wb_en = wrEn & ~(pcWrEn & (wrAddr == PC_IDX));

    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            addr[i] = rdAddr[i*ADDR_W +: ADDR_W];
        end
    end

    // Write-first bypass; for the PC, pcIn takes priority over wrData.
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            fwd[i] = mem[addr[i]];
            if (wrEn && (wrAddr == addr[i])) begin
                fwd[i] = wrData;
            end
            if (pcWrEn && (addr[i] == PC_IDX)) begin
                fwd[i] = pcIn;
            end
        end
    end

`ifdef REGBANK_SCOREBOARD_EN
    logic [DEPTH-1:0]  lock;
    logic [NUM_RD-1:0] blocked;

    // A locked read stalls unless its pending write lands this very cycle.
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            blocked[i] = rdReq[i] & lock[addr[i]]
                       & ~(wrEn & (wrAddr == addr[i]));
        end
    end

    assign rdReady = {NUM_RD{~rst}} & ~blocked;

    // Set beats clear on the same index: the set marks a newer pending write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock <= '0;
        end else begin
            for (int j = 0; j < DEPTH; j++) begin
                if (lockSet && (lockAddr == ADDR_W'(j))
                    && (ADDR_W'(j) != PC_IDX)) begin
                    lock[j] <= 1'b1;
                end else if (wrEn && (wrAddr == ADDR_W'(j))) begin
                    lock[j] <= 1'b0;
                end
            end
        end
    end
`else
    assign rdReady = {NUM_RD{~rst}};
`endif

    assign accept = rdReq & rdReady;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdValid <= '0;
            rdData  <= '0;
        end else begin
            rdValid <= accept;
            for (int i = 0; i < NUM_RD; i++) begin
                if (accept[i]) begin
                    rdData[i*DATA_W +: DATA_W] <= fwd[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < DEPTH; j++) begin
                mem[j] <= '0;
            end
        end else begin
            if (wb_en) begin
                mem[wrAddr] <= wrData;
            end
            if (pcWrEn) begin
                mem[PC_IDX] <= pcIn;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpsr <= '0;
        end else if (cpsrWrEn) begin
            cpsr <= cpsrIn;
        end
    end

    assign pcOut   = mem[PC_IDX];
    assign cpsrOut = cpsr;

endmodule

// File: doc/regbank_mp.md
Name: regbank_mp

Overview:
- Parametrised, clocked, multi-read-port general register bank for the async ARM core.
- Serves the decoder/operand-fetch stage through NUM_RD independent read ports with valid/ready handshake.
- Accepts one writeback write per cycle, holds PC (top register) for fetch and CPSR for issue.
- Write-to-read bypass included; optional scoreboard locking stalls reads of registers with pending writebacks.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 4, register index width; DEPTH = 2**ADDR_W, PC = register DEPTH-1
- NUM_RD, 2, number of read ports

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous active-high reset
- rdReq  in  NUM_RD  per-port read request
- rdAddr  in  NUM_RD*ADDR_W  per-port read index; port i at bits [i*ADDR_W +: ADDR_W]
- rdReady  out  NUM_RD  port can accept a request this cycle
- rdValid  out  NUM_RD  read data valid, one-cycle pulse per accepted request
- rdData  out  NUM_RD*DATA_W  per-port read data, packed like rdAddr
- wrEn  in  1  writeback write enable
- wrAddr  in  ADDR_W  writeback index
- wrData  in  DATA_W  writeback data
- pcWrEn  in  1  fetch PC update enable
- pcIn  in  DATA_W  next PC from fetch
- pcOut  out  DATA_W  current PC (register DEPTH-1)
- cpsrWrEn  in  1  CPSR update enable
- cpsrIn  in  DATA_W  new CPSR value
- cpsrOut  out  DATA_W  current CPSR

Behaviour:
- Reset (async, rst=1): all DEPTH registers, CPSR, rdValid, rdData = 0; pcOut = 0, cpsrOut = 0; rdReady = all ones once rst deasserts.
- Read accept: rdReq[i] & rdReady[i] at edge k -> rdValid[i]=1 and rdData[i] valid in cycle k+1; rdValid low next cycle unless another request is accepted. Fully pipelined: one request per port per cycle; ports independent, same address on several ports allowed.
- rdData[i] holds its last value when rdValid[i]=0.
- Without the optional feature, rdReady is constantly 1 outside reset.
- Write: wrEn at edge k updates mem[wrAddr] at that edge.
- Bypass: a read accepted in the same cycle as a write to the same index returns the new wrData (write-first).
- PC: pcWrEn loads register DEPTH-1 from pcIn. If wrEn targets DEPTH-1 in the same cycle, pcWrEn wins and the writeback is dropped. pcOut is the registered value, updated the cycle after the load. Reads of DEPTH-1 return PC with the same bypass priority: pcIn, then wrData.
- CPSR: cpsrWrEn loads CPSR; cpsrOut = CPSR register, one-cycle latency. CPSR is not addressable by read ports.
- Reset mid-operation: in-flight rdValid pulses are cleared immediately; no request is carried across reset.

Optional Feature:
- Macro: REGBANK_SCOREBOARD_EN
- Defined: adds ports lockSet (in 1), lockAddr (in ADDR_W) and DEPTH-bit lock vector (reset 0).
- lockSet at edge sets lock[lockAddr]; a wrEn write to an index clears its lock at the same edge. Clear wins over set only when lockAddr != wrAddr; set and write to the same index leaves it locked (new pending write).
- rdReady[i]=0 while rdReq[i] is high and lock[rdAddr[i]]=1, unless that cycle's wrEn targets the same index. In that case the read is accepted with bypassed data.
- The requester holds rdReq/rdAddr stable until accepted. PC (DEPTH-1) is never locked; lockSet to DEPTH-1 is ignored.
- Undefined: no lock ports, rdReady tied high, no lock state.

Test Plan:
- Reset then read R3 on port 0 -> rdValid[0] pulses in cycle after request, rdData[0]=0x0.
- Write R5=0xDEADBEEF; next cycle read R5 on both ports simultaneously -> both rdValid high together, both rdData=0xDEADBEEF.
- Same-cycle wrEn R2=0x1234 and read R2 on port 1 -> rdData[1]=0x1234 (bypass).
- pcWrEn pcIn=0x100 with wrEn R15=0x200 same cycle -> pcOut=0x100 next cycle; read R15 returns 0x100. cpsrWrEn 0x6000001F -> cpsrOut=0x6000001F next cycle.
- Assert rst during an accepted read -> rdValid drops to 0 immediately; after release, all registers read 0.
- (REGBANK_SCOREBOARD_EN) lockSet R4, then read R4 -> rdReady[0]=0 for 3 cycles; wrEn R4=0x55 -> read accepted that cycle, rdData=0x55, lock[4] cleared.
